// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned FETCH_XLEN    = 32;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    KILL
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] instr;
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] pc_plus4;
    logic                  valid;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_pipe_if.sv
// Instruction-memory request/response handshake (req/gnt, then rvalid).
interface fetch_stage_pipe_if #(
  parameter int unsigned XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_gnt, imem_rvalid, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_gnt, imem_rvalid, imem_rdata);
endinterface

// File: rtl/fetch_pc_gen.sv
// Fetch PC register with redirect/increment next-PC selection.
module fetch_pc_gen #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect,
  input  logic [XLEN-1:0] target,
  input  logic            advance,
  output logic [XLEN-1:0] PCF
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      PCF <= RESET_PC;
    else if (redirect)
      PCF <= {target[XLEN-1:2], 2'b00};
    else if (advance)
      PCF <= PCF + XLEN'(4);
  end

endmodule

// File: rtl/fetch_stage_pipe.sv
// Instruction-fetch stage: one outstanding imem request, 1-entry hold buffer, IF/ID register.
module fetch_stage_pipe
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN      = FETCH_XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DEF),
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(NOP_INSTR_DEF)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                PCSrcE,
  input  logic [XLEN-1:0]     PCTargetE,
  input  logic                StallF,
  input  logic                StallD,
  input  logic                FlushD,
  fetch_stage_pipe_if.master  imem,
  output logic [XLEN-1:0]     InstrD,
  output logic [XLEN-1:0]     PCD,
  output logic [XLEN-1:0]     PCPlus4D,
  output logic                ValidD,
  output logic [XLEN-1:0]     PCF
);

  localparam if_id_t BUBBLE = '{instr: FETCH_XLEN'(NOP_INSTR), pc: '0, pc_plus4: '0, valid: 1'b0};

  fetch_state_e    state;
  logic [XLEN-1:0] pendPc;
  if_id_t          holdQ;
  if_id_t          ifId;
  if_id_t          rspTuple;
  logic            req;
  logic            advance;
  logic            rsp;

  fetch_pc_gen #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk      (clk),
    .rst      (rst),
    .redirect (PCSrcE),
    .target   (PCTargetE),
    .advance  (advance),
    .PCF      (PCF)
  );

  assign req     = !rst && (state == FETCH) && !StallF && !PCSrcE && !holdQ.valid;
  assign advance = req && imem.imem_gnt;
  // A response arriving together with a redirect belongs to the old path.
  assign rsp     = (state == WAIT) && imem.imem_rvalid && !PCSrcE;

  assign imem.imem_req  = req;
  assign imem.imem_addr = PCF;

  always_comb begin
    rspTuple          = BUBBLE;
    rspTuple.instr    = FETCH_XLEN'(imem.imem_rdata);
    rspTuple.pc       = FETCH_XLEN'(pendPc);
    rspTuple.pc_plus4 = FETCH_XLEN'(pendPc + XLEN'(4));
    rspTuple.valid    = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= FETCH;
      pendPc <= '0;
    end else begin
      case (state)
        FETCH: if (advance) begin
          pendPc <= PCF;
          state  <= WAIT;
        end
        WAIT: begin
          if (imem.imem_rvalid)
            state <= FETCH;
          else if (PCSrcE)
            state <= KILL;
        end
        KILL: if (imem.imem_rvalid) state <= FETCH;
        default: state <= FETCH;
      endcase
    end
  end

  // The buffer is drained only without a redirect: its contents are younger than the branch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifId  <= BUBBLE;
      holdQ <= BUBBLE;
    end else begin
      if (FlushD)
        ifId <= BUBBLE;
      else if (!StallD) begin
        if (holdQ.valid && !PCSrcE)
          ifId <= holdQ;
        else if (rsp)
          ifId <= rspTuple;
        else
          ifId <= BUBBLE;
      end

      if (FlushD || PCSrcE || !StallD)
        holdQ <= BUBBLE;
      else if (rsp)
        holdQ <= rspTuple;
    end
  end

  assign InstrD   = XLEN'(ifId.instr);
  assign PCD      = XLEN'(ifId.pc);
  assign PCPlus4D = XLEN'(ifId.pc_plus4);
  assign ValidD   = ifId.valid;

endmodule

// File: tb/tb_fetch_stage_pipe.sv
// Directed bench for fetch_stage_pipe with a scoreboard of expected decode-stage instructions.
module tb_fetch_stage_pipe;
  import fetch_pkg::*;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] RPC  = 32'h0000_0100;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic            clk = 1'b0;
  logic            rst;
  logic            PCSrcE;
  logic [XLEN-1:0] PCTargetE;
  logic            StallF;
  logic            StallD;
  logic            FlushD;
  logic [XLEN-1:0] InstrD;
  logic [XLEN-1:0] PCD;
  logic [XLEN-1:0] PCPlus4D;
  logic            ValidD;
  logic [XLEN-1:0] PCF;

  fetch_stage_pipe_if #(.XLEN(XLEN)) imem ();

  fetch_stage_pipe #(
    .XLEN      (XLEN),
    .RESET_PC  (RPC),
    .NOP_INSTR (NOP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .StallF    (StallF),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .imem      (imem),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD),
    .PCF       (PCF)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int   nVec = 0;
  int   nErr = 0;
  logic monStall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic zeroWait(input logic [31:0] instr, input logic [31:0] pc);
    imem.imem_gnt    = 1'b1;
    imem.imem_rvalid = 1'b0;
    cyc();
    imem.imem_gnt    = 1'b0;
    imem.imem_rvalid = 1'b1;
    imem.imem_rdata  = instr;
    sb.push_back('{instr: instr, pc: pc});
    cyc();
    imem.imem_rvalid = 1'b0;
  endtask

  // A fresh IF/ID load is visible whenever ValidD is set after an unstalled edge.
  always @(posedge clk) begin
    exp_t e;
    monStall = StallD;
    #1;
    if (!rst && !monStall && ValidD) begin
      if (sb.size() == 0) begin
        nVec++;
        nErr++;
        $error("FAIL sb_unexpected: observed InstrD %h PCD %h expected no instruction", InstrD, PCD);
      end else begin
        e = sb.pop_front();
        chk("InstrD", InstrD, e.instr);
        chk("PCD", PCD, e.pc);
        chk("PCPlus4D", PCPlus4D, e.pc + 32'd4);
      end
    end
  end

  initial begin
    #200000;
    $error("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; PCSrcE = 1'b0; PCTargetE = '0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    imem.imem_gnt = 1'b0; imem.imem_rvalid = 1'b0; imem.imem_rdata = '0;
    cyc(); cyc();
    chk("rst_ValidD", {31'b0, ValidD}, 32'd0);
    chk("rst_InstrD", InstrD, NOP);
    chk("rst_PCD", PCD, 32'd0);
    chk("rst_PCPlus4D", PCPlus4D, 32'd0);
    chk("rst_PCF", PCF, RPC);
    chk("rst_req", {31'b0, imem.imem_req}, 32'd0);

    // zero-wait A, B, C
    rst = 1'b0; imem.imem_gnt = 1'b1; #1;
    chk("a_req", {31'b0, imem.imem_req}, 32'd1);
    chk("a_addr", imem.imem_addr, 32'h100);
    cyc();
    chk("a_PCF", PCF, 32'h104);
    chk("a_bubble", {31'b0, ValidD}, 32'd0);
    imem.imem_gnt = 1'b0; imem.imem_rvalid = 1'b1; imem.imem_rdata = 32'hAAAA_0001;
    sb.push_back('{instr: 32'hAAAA_0001, pc: 32'h100});
    #1;
    chk("wait_req", {31'b0, imem.imem_req}, 32'd0);
    cyc();
    imem.imem_rvalid = 1'b0; #1;
    chk("b_addr", imem.imem_addr, 32'h104);
    zeroWait(32'hBBBB_0002, 32'h104);
    zeroWait(32'hCCCC_0003, 32'h108);

    // grant withheld for three cycles
    for (int unsigned i = 0; i < 3; i++) begin
      chk("nognt_req", {31'b0, imem.imem_req}, 32'd1);
      chk("nognt_addr", imem.imem_addr, 32'h10C);
      cyc();
      chk("nognt_PCF", PCF, 32'h10C);
    end
    imem.imem_gnt = 1'b1;
    cyc();
    chk("gnt_PCF", PCF, 32'h110);
    imem.imem_gnt = 1'b0; imem.imem_rvalid = 1'b1; imem.imem_rdata = 32'hDDDD_0004;
    sb.push_back('{instr: 32'hDDDD_0004, pc: 32'h10C});
    cyc();
    imem.imem_rvalid = 1'b0;

    // decode stall catches F in the hold buffer
    zeroWait(32'hEEEE_0005, 32'h110);
    StallD = 1'b1; imem.imem_gnt = 1'b1;
    cyc();
    imem.imem_rvalid = 1'b1; imem.imem_rdata = 32'hFFFF_0006;
    cyc();
    imem.imem_rvalid = 1'b0; #1;
    chk("hold_req", {31'b0, imem.imem_req}, 32'd0);
    chk("hold_InstrD", InstrD, 32'hEEEE_0005);
    chk("hold_PCD", PCD, 32'h110);
    chk("hold_PCF", PCF, 32'h118);
    cyc();
    chk("hold2_req", {31'b0, imem.imem_req}, 32'd0);
    chk("hold2_InstrD", InstrD, 32'hEEEE_0005);
    StallD = 1'b0;
    sb.push_back('{instr: 32'hFFFF_0006, pc: 32'h114});
    cyc();
    chk("drain_req", {31'b0, imem.imem_req}, 32'd1);
    chk("drain_addr", imem.imem_addr, 32'h118);

    // redirect while a request is outstanding
    cyc();
    imem.imem_gnt = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'h203;
    cyc();
    chk("redir_PCF", PCF, 32'h200);
    PCSrcE = 1'b0; imem.imem_rvalid = 1'b1; imem.imem_rdata = 32'hDEAD_0000; #1;
    chk("kill_req", {31'b0, imem.imem_req}, 32'd0);
    cyc();
    imem.imem_rvalid = 1'b0; #1;
    chk("kill_ValidD", {31'b0, ValidD}, 32'd0);
    chk("redir_req", {31'b0, imem.imem_req}, 32'd1);
    chk("redir_addr", imem.imem_addr, 32'h200);
    zeroWait(32'h1111_0007, 32'h200);

    // flush wins over stall
    FlushD = 1'b1; StallD = 1'b1;
    cyc();
    chk("flush_ValidD", {31'b0, ValidD}, 32'd0);
    chk("flush_InstrD", InstrD, NOP);
    chk("flush_PCD", PCD, 32'd0);
    chk("flush_PCPlus4D", PCPlus4D, 32'd0);
    FlushD = 1'b0; StallD = 1'b0;

    // redirect coinciding with rvalid drops the response
    imem.imem_gnt = 1'b1;
    cyc();
    imem.imem_gnt = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'h300;
    imem.imem_rvalid = 1'b1; imem.imem_rdata = 32'hDEAD_0001;
    cyc();
    PCSrcE = 1'b0; imem.imem_rvalid = 1'b0; #1;
    chk("drop_ValidD", {31'b0, ValidD}, 32'd0);
    chk("drop_req", {31'b0, imem.imem_req}, 32'd1);
    chk("drop_addr", imem.imem_addr, 32'h300);

    // redirect in FETCH beats the request; StallF suppresses it
    PCSrcE = 1'b1; PCTargetE = 32'h400; imem.imem_gnt = 1'b1; #1;
    chk("redirF_req", {31'b0, imem.imem_req}, 32'd0);
    cyc();
    chk("redirF_PCF", PCF, 32'h400);
    PCSrcE = 1'b0; StallF = 1'b1; #1;
    chk("stallF_req", {31'b0, imem.imem_req}, 32'd0);
    cyc();
    chk("stallF_PCF", PCF, 32'h400);
    StallF = 1'b0; imem.imem_gnt = 1'b0;

    // PC wraps modulo 2^XLEN
    PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFF;
    cyc();
    PCSrcE = 1'b0;
    chk("wrap_PCF", PCF, 32'hFFFF_FFFC);
    zeroWait(32'h2222_0008, 32'hFFFF_FFFC);
    chk("wrap_PCF0", PCF, 32'h0);

    // spurious rvalid in FETCH
    imem.imem_rvalid = 1'b1; imem.imem_rdata = 32'hDEAD_0002;
    cyc();
    imem.imem_rvalid = 1'b0;
    chk("spur_ValidD", {31'b0, ValidD}, 32'd0);

    // reset while waiting abandons the request
    imem.imem_gnt = 1'b1;
    cyc();
    imem.imem_gnt = 1'b0; rst = 1'b1; #1;
    chk("rstw_PCF", PCF, RPC);
    chk("rstw_req", {31'b0, imem.imem_req}, 32'd0);
    imem.imem_rvalid = 1'b1; imem.imem_rdata = 32'hDEAD_0003;
    cyc(); cyc();
    chk("rstw_ValidD", {31'b0, ValidD}, 32'd0);
    chk("rstw_InstrD", InstrD, NOP);
    imem.imem_rvalid = 1'b0; rst = 1'b0; imem.imem_gnt = 1'b1; #1;
    chk("rel_req", {31'b0, imem.imem_req}, 32'd1);
    chk("rel_addr", imem.imem_addr, RPC);
    zeroWait(32'h3333_0009, RPC);
    cyc();

    chk("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
